seg_scan_scheduler: RTL and testbench

Time-multiplexing scheduler that shares one 7-segment segment bus between four common-anode-enabled digits. Sits between the BCD counter registers (units..thousands) and the board display pins. Sequences a blank/show cycle per digit, captures a tear-free frame snapshot, and provides leading-zero suppression and 16-step brightness PWM.

---
 rtl/seg_scan_scheduler.sv | 116 +++++++++++
 tb/tb_seg_scan_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_scheduler.sv
// Four-digit 7-segment scan scheduler: blank/show sequencing per digit, per-frame
// input snapshot, leading-zero suppression and 16-step brightness PWM on the digit enable.
module seg_scan_scheduler #(
   parameter int DWELL_CYCLES = 25000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] bcd,
   input  logic        lz_en,
   input  logic [3:0]  brightness,
   output logic [6:0]  seg,
   output logic [3:0]  digit,
   output logic        frame_start
);

   localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CW   = $clog2(MAXC);
   localparam int TW   = CW + 5;
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [TW-1:0] PWM_STEP   = TW'(DWELL_CYCLES / 16);

   typedef enum logic {BLANK, SHOW} state_t;

   state_t        state;
   logic [1:0]    idx;
   logic [CW-1:0] cnt;
   logic [15:0]   bcd_s;
   logic [3:0]    bright_s;
   logic          lz_s;

   logic [3:0]    nib;
   logic [3:0]    nz;
   logic          supp;
   logic [TW-1:0] thr;

   function automatic logic [6:0] decode(input logic [3:0] n);
      case (n)
         4'd0:    decode = 7'h3F;
         4'd1:    decode = 7'h06;
         4'd2:    decode = 7'h5B;
         4'd3:    decode = 7'h4F;
         4'd4:    decode = 7'h66;
         4'd5:    decode = 7'h6D;
         4'd6:    decode = 7'h7D;
         4'd7:    decode = 7'h07;
         4'd8:    decode = 7'h7F;
         4'd9:    decode = 7'h6F;
         default: decode = 7'h40;
      endcase
   endfunction

   always_comb begin
      nib = bcd_s[{idx, 2'b00} +: 4];
      for (int i = 0; i < 4; i++) nz[i] = (bcd_s[4*i +: 4] != 4'd0);
      // A digit is blanked only when it and every more significant digit are zero.
      supp = 1'b0;
      case (idx)
         2'd1:    supp = lz_s && !(nz[1] || nz[2] || nz[3]);
         2'd2:    supp = lz_s && !(nz[2] || nz[3]);
         2'd3:    supp = lz_s && !nz[3];
         default: supp = 1'b0;
      endcase
      thr = TW'({1'b0, bright_s} + 5'd1) * PWM_STEP;
   end

   // Outputs are registered for the cycle being entered; the snapshot is taken on the
   // same edge that enters the first blank cycle of digit 0, before any SHOW uses it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= BLANK;
         idx         <= 2'd0;
         cnt         <= '0;
         bcd_s       <= 16'h0000;
         bright_s    <= 4'd0;
         lz_s        <= 1'b0;
         seg         <= 7'h00;
         digit       <= 4'h0;
         frame_start <= 1'b0;
      end else begin
         case (state)
            BLANK: begin
               seg         <= 7'h00;
               digit       <= 4'h0;
               frame_start <= (idx == 2'd0) && (cnt == '0);
               if ((idx == 2'd0) && (cnt == '0)) begin
                  bcd_s    <= bcd;
                  bright_s <= brightness;
                  lz_s     <= lz_en;
               end
               if (cnt == BLANK_LAST) begin
                  state <= SHOW;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SHOW: begin
               frame_start <= 1'b0;
               seg         <= supp ? 7'h00 : decode(nib);
               digit       <= (!supp && (TW'(cnt) < thr)) ? (4'b0001 << idx) : 4'h0;
               if (cnt == DWELL_LAST) begin
                  state <= BLANK;
                  cnt   <= '0;
                  idx   <= idx + 2'd1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= BLANK;
         endcase
      end
   end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Bench for seg_scan_scheduler: a time-position model of the scan (cycle index since
// reset release, modulo the frame) predicts every output cycle by cycle.
module tb_seg_scan_scheduler;

   localparam int DWELL = 32;
   localparam int BLANK = 4;
   localparam int SLOT  = DWELL + BLANK;
   localparam int FRAME = 4 * SLOT;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] bcd;
   logic        lz_en;
   logic [3:0]  brightness;
   logic [6:0]  seg;
   logic [3:0]  digit;
   logic        frame_start;

   int passed = 0;
   int total  = 0;

   int          t;
   logic [15:0] snap_bcd;
   logic [3:0]  snap_br;
   logic        snap_lz;
   logic [6:0]  exp_seg;
   logic [3:0]  exp_digit;
   logic        exp_fs;

   seg_scan_scheduler #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)) dut (
      .clk(clk), .rst_n(rst_n), .bcd(bcd), .lz_en(lz_en), .brightness(brightness),
      .seg(seg), .digit(digit), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] ref_decode(input int n);
      case (n)
         0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
         4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
         8: return 7'h7F;  9: return 7'h6F;
         default: return 7'h40;
      endcase
   endfunction

   // Advance one clock and compute what the outputs must be in the cycle just entered.
   task automatic step();
      logic [15:0] pend_bcd;
      logic [3:0]  pend_br;
      logic        pend_lz;
      int pos, slot, off, s, nibv, upper;
      logic sup;
      pend_bcd = bcd; pend_br = brightness; pend_lz = lz_en;
      @(posedge clk);
      #1;
      t++;
      pos = t % FRAME;
      if (pos == 0) begin
         snap_bcd = pend_bcd; snap_br = pend_br; snap_lz = pend_lz;
      end
      slot   = pos / SLOT;
      off    = pos % SLOT;
      exp_fs = (pos == 0);
      exp_seg = 7'h00;
      exp_digit = 4'h0;
      if (off >= BLANK) begin
         s     = off - BLANK;
         nibv  = (snap_bcd >> (4 * slot)) & 16'hF;
         upper = snap_bcd >> (4 * slot);
         sup   = snap_lz && (slot > 0) && (upper == 0);
         if (!sup) begin
            exp_seg = ref_decode(nibv);
            if (s < ((int'(snap_br) + 1) * DWELL) / 16) exp_digit = 4'(1 << slot);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; bcd = 16'h1234; brightness = 4'd15; lz_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         total++;
         if ({frame_start, digit, seg} !== 12'h000) begin
            $display("FAIL reset cyc=%0d got fs=%b dig=%b seg=%h want 0", i, frame_start, digit, seg);
         end else passed++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      t = -1;
   endtask

   task automatic test_basic();
      for (int i = 0; i < FRAME + 10; i++) begin
         step();
         total++;
         if ({frame_start, digit, seg} !== {exp_fs, exp_digit, exp_seg}) begin
            $display("FAIL basic t=%0d got fs=%b dig=%b seg=%h want fs=%b dig=%b seg=%h",
                     t, frame_start, digit, seg, exp_fs, exp_digit, exp_seg);
         end else passed++;
      end
   endtask

   task automatic test_lz(input logic [15:0] v);
      bcd = v; lz_en = 1'b1; brightness = 4'd15;
      for (int i = 0; i < 2 * FRAME; i++) begin
         step();
         total++;
         if ({frame_start, digit, seg} !== {exp_fs, exp_digit, exp_seg}) begin
            $display("FAIL lz_%h t=%0d got fs=%b dig=%b seg=%h want fs=%b dig=%b seg=%h",
                     v, t, frame_start, digit, seg, exp_fs, exp_digit, exp_seg);
         end else passed++;
      end
   endtask

   task automatic test_brightness();
      bcd = 16'h5678; lz_en = 1'b0; brightness = 4'd3;
      for (int i = 0; i < 2 * FRAME; i++) begin
         step();
         total++;
         if ({frame_start, digit, seg} !== {exp_fs, exp_digit, exp_seg}) begin
            $display("FAIL bright t=%0d got fs=%b dig=%b seg=%h want fs=%b dig=%b seg=%h",
                     t, frame_start, digit, seg, exp_fs, exp_digit, exp_seg);
         end else passed++;
      end
      brightness = 4'd0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         step();
         total++;
         if ({frame_start, digit, seg} !== {exp_fs, exp_digit, exp_seg}) begin
            $display("FAIL bright0 t=%0d got fs=%b dig=%b seg=%h want fs=%b dig=%b seg=%h",
                     t, frame_start, digit, seg, exp_fs, exp_digit, exp_seg);
         end else passed++;
      end
   endtask

   task automatic test_midframe_change();
      bcd = 16'h1111; lz_en = 1'b0; brightness = 4'd15;
      // align to a frame whose snapshot holds 1111, then move into digit 1's SHOW
      for (int i = 0; i < 2 * FRAME; i++) begin
         step();
         if ((t % FRAME) == 0 && snap_bcd == 16'h1111) break;
      end
      for (int i = 0; i < FRAME; i++) begin
         step();
         if ((t % FRAME) == SLOT + BLANK + 5) break;
      end
      bcd = 16'h9999;
      for (int i = 0; i < 2 * FRAME; i++) begin
         step();
         total++;
         if ({frame_start, digit, seg} !== {exp_fs, exp_digit, exp_seg}) begin
            $display("FAIL midframe t=%0d got fs=%b dig=%b seg=%h want fs=%b dig=%b seg=%h",
                     t, frame_start, digit, seg, exp_fs, exp_digit, exp_seg);
         end else passed++;
      end
   endtask

   task automatic test_async_reset();
      bcd = 16'h4321; lz_en = 1'b0; brightness = 4'd15;
      for (int i = 0; i < 2 * FRAME; i++) begin
         step();
         if ((t % FRAME) == 2 * SLOT + BLANK + 6) break;
      end
      total++;
      if (digit !== 4'b0100) begin
         $display("FAIL pre_reset_digit got %b want 0100", digit);
      end else passed++;
      rst_n = 1'b0;
      #1;
      total++;
      if ({frame_start, digit, seg} !== 12'h000) begin
         $display("FAIL async_reset got fs=%b dig=%b seg=%h want 0", frame_start, digit, seg);
      end else passed++;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({frame_start, digit, seg} !== 12'h000) begin
         $display("FAIL held_reset got fs=%b dig=%b seg=%h want 0", frame_start, digit, seg);
      end else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      t = -1;
      for (int i = 0; i < FRAME + 20; i++) begin
         step();
         total++;
         if ({frame_start, digit, seg} !== {exp_fs, exp_digit, exp_seg}) begin
            $display("FAIL after_reset t=%0d got fs=%b dig=%b seg=%h want fs=%b dig=%b seg=%h",
                     t, frame_start, digit, seg, exp_fs, exp_digit, exp_seg);
         end else passed++;
      end
   endtask

   task automatic test_random();
      logic [15:0] masks [4] = '{16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF};
      for (int i = 0; i < 6 * FRAME; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            bcd        = 16'($urandom) & masks[$urandom_range(0, 3)];
            brightness = 4'($urandom_range(0, 15));
            lz_en      = 1'($urandom_range(0, 1));
         end
         step();
         total++;
         if ({frame_start, digit, seg} !== {exp_fs, exp_digit, exp_seg}) begin
            $display("FAIL random t=%0d got fs=%b dig=%b seg=%h want fs=%b dig=%b seg=%h",
                     t, frame_start, digit, seg, exp_fs, exp_digit, exp_seg);
         end else passed++;
      end
   endtask

   initial begin
      t = -1;
      snap_bcd = 16'h0; snap_br = 4'h0; snap_lz = 1'b0;
      test_reset();
      test_basic();
      test_lz(16'h0007);
      test_lz(16'h0000);
      test_lz(16'h00A0);
      test_brightness();
      test_midframe_change();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
